// File: rtl/wallace_mac_accumulator_pkg.sv
// Shared types and constants for the Wallace-tree multiply-accumulate slice.
package wallace_mac_accumulator_pkg;

  localparam int PROD_W      = 16;
  localparam int DEF_N_TERMS = 16;
  localparam int DEF_ACC_W   = 20;

  typedef enum logic {
    GRP_IDLE = 1'b0,
    GRP_RUN  = 1'b1
  } grp_state_e;

  // Width needed to hold a term count of 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/eight_bit_wallace_tree.sv
// Unsigned 8x8 multiplier: partial products reduced by a carry-save (Wallace) tree,
// finished with a single carry-propagate add.
module eight_bit_wallace_tree (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] s
);

  function automatic logic [15:0] xor3(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] maj3(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] pp [8];

  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = b[i] ? (16'(a) << i) : 16'd0;
  end

  // 8 rows -> 6 -> 4 -> 3 -> 2; product always fits 16 bits so truncation is exact.
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  assign s0 = xor3(pp[0], pp[1], pp[2]);
  assign c0 = maj3(pp[0], pp[1], pp[2]);
  assign s1 = xor3(pp[3], pp[4], pp[5]);
  assign c1 = maj3(pp[3], pp[4], pp[5]);

  assign s2 = xor3(s0, c0, s1);
  assign c2 = maj3(s0, c0, s1);
  assign s3 = xor3(c1, pp[6], pp[7]);
  assign c3 = maj3(c1, pp[6], pp[7]);

  assign s4 = xor3(s2, c2, s3);
  assign c4 = maj3(s2, c2, s3);

  assign s5 = xor3(s4, c4, c3);
  assign c5 = maj3(s4, c4, c3);

  assign s = s5 + c5;

endmodule

// File: rtl/mac_acc_sat_add.sv
// Accumulator adder: adds a 16-bit product, flags carry-out, optionally saturates.
module mac_acc_sat_add
  import wallace_mac_accumulator_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] nxt;

  assign nxt   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry = nxt[ACC_W];
  assign sum   = (SAT_EN && carry) ? {ACC_W{1'b1}} : nxt[ACC_W-1:0];

endmodule

// File: rtl/wallace_mac_accumulator.sv
// Three-stage multiply-accumulate: operand capture, Wallace multiply, grouped accumulate.
// state    | meaning
// GRP_IDLE | no term of the current group accumulated yet (acc=0, cnt=0)
// GRP_RUN  | group open, at least one term accumulated
module wallace_mac_accumulator
  import wallace_mac_accumulator_pkg::*;
#(
  parameter int  N_TERMS = DEF_N_TERMS,
  parameter int  ACC_W   = DEF_ACC_W,
  parameter bit  SAT_EN  = 1'b1,
  localparam int CNT_W   = cnt_w(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic              en;
  logic              xfer;
  logic              s1_vld, s1_last;
  logic [7:0]        s1_a, s1_b;
  logic              s2_vld, s2_last;
  logic [PROD_W-1:0] s2_prod;
  logic [PROD_W-1:0] mult_s;
  logic [ACC_W-1:0]  acc, acc_base, add_sum;
  logic              add_carry;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ovf, ovf_n;
  logic              close;
  grp_state_e        state_q, state_d;

  // A stalled result freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = rst_n && en && !clear;
  assign xfer     = in_valid && in_ready;

  eight_bit_wallace_tree u_mult (
    .a (s1_a),
    .b (s1_b),
    .s (mult_s)
  );

  assign acc_base = (state_q == GRP_IDLE) ? '0 : acc;

  mac_acc_sat_add #(
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_add (
    .acc   (acc_base),
    .prod  (s2_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_n   = cnt + CNT_W'(1);
    ovf_n   = ovf || add_carry;
    close   = s2_vld && (s2_last || (cnt_n == CNT_W'(N_TERMS)));
    case (state_q)
      GRP_IDLE: if (en && s2_vld && !close) state_d = GRP_RUN;
      GRP_RUN:  if (en && close)            state_d = GRP_IDLE;
      default:                              state_d = GRP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_vld    <= 1'b0;
      s2_last   <= 1'b0;
      s2_prod   <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      state_q   <= GRP_IDLE;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      state_q   <= GRP_IDLE;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
      s2_vld    <= s1_vld;
      s2_last   <= s1_last;
      s2_prod   <= mult_s;
      state_q   <= state_d;
      out_valid <= close;
      if (close) begin
        out_sum   <= add_sum;
        out_count <= cnt_n;
        out_ovf   <= ovf_n;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else if (s2_vld) begin
        acc <= add_sum;
        cnt <= cnt_n;
        ovf <= ovf_n;
      end
    end
  end

endmodule
